// File: rtl/polyshift_pipe_pkg.sv
// ---------------------------------------------------------------------------
// polyshift_pipe_pkg
// Shared types and helpers for the pipelined poly-shifter.
//   SHIFT_TYPE : shift kind (logical, arithmetic, through-carry, rotate)
//   SHIFT_DIR  : shift direction (LEFT, RIGHT)
//   ps_ctrl_t  : control fields that travel alongside the data in each rank
//   ps_level_count / ps_first_level : how shift levels are split over ranks
// ---------------------------------------------------------------------------
package polyshift_pipe_pkg;

    typedef enum logic [1:0] {
        SHIFT_LOGIC  = 2'd0,
        SHIFT_ARITH  = 2'd1,
        SHIFT_CARRY  = 2'd2,
        SHIFT_ROTATE = 2'd3
    } SHIFT_TYPE;

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } SHIFT_DIR;

    // Width-independent part of the per-rank payload. The data, carry and
    // size fields depend on word_width, so the full payload struct is built
    // around this one inside the top module.
    typedef struct packed {
        logic      valid;
        logic      sign;
        SHIFT_TYPE stype;
        SHIFT_DIR  dir;
    } ps_ctrl_t;

    // Number of shift levels placed in a given rank; any remainder of the
    // even split goes to the earliest ranks.
    function automatic int ps_level_count(input int rank, input int levels, input int ranks);
        return (levels / ranks) + ((rank < (levels % ranks)) ? 1 : 0);
    endfunction

    // Index of the first shift level handled by a given rank.
    function automatic int ps_first_level(input int rank, input int levels, input int ranks);
        return rank * (levels / ranks) + ((rank < (levels % ranks)) ? rank : (levels % ranks));
    endfunction

endpackage

// File: rtl/polyshift_pipe_level.sv
// ---------------------------------------------------------------------------
// polyshift_level
// One combinational shift level: shifts by DIST bit positions when en_i is
// set, otherwise passes data and carry through untouched.
//   data_i / data_o   : operand in, shifted operand out
//   carry_i / carry_o : remaining carry-fill word in and out
//   sign_i            : original operand sign bit (arithmetic right fill)
//   stype_i, dir_i    : shift kind and direction
//   en_i              : size bit selecting this level
// ---------------------------------------------------------------------------
module polyshift_level
    import polyshift_pipe_pkg::*;
#(
    parameter int W    = 8,
    parameter int DIST = 1
) (
    input  logic [W-1:0] data_i,
    input  logic [W-2:0] carry_i,
    input  logic         sign_i,
    input  SHIFT_TYPE    stype_i,
    input  SHIFT_DIR     dir_i,
    input  logic         en_i,
    output logic [W-1:0] data_o,
    output logic [W-2:0] carry_o
);

    // The carry word behaves like an extension of the operand: bits leaving
    // it enter the data word, and it is itself shifted so that later levels
    // pick up the next fill bits in sequence.
    always_comb begin
        data_o  = data_i;
        carry_o = carry_i;
        if (en_i) begin
            if (dir_i == LEFT) begin
                case (stype_i)
                    SHIFT_CARRY: begin
                        data_o  = {data_i[W-1-DIST:0], carry_i[W-2 -: DIST]};
                        carry_o = {carry_i[W-2-DIST:0], {DIST{1'b0}}};
                    end
                    SHIFT_ROTATE: data_o = {data_i[W-1-DIST:0], data_i[W-1 -: DIST]};
                    default:      data_o = {data_i[W-1-DIST:0], {DIST{1'b0}}};
                endcase
            end else begin
                case (stype_i)
                    SHIFT_ARITH: data_o = {{DIST{sign_i}}, data_i[W-1:DIST]};
                    SHIFT_CARRY: begin
                        data_o  = {carry_i[DIST-1:0], data_i[W-1:DIST]};
                        carry_o = {{DIST{1'b0}}, carry_i[W-2:DIST]};
                    end
                    SHIFT_ROTATE: data_o = {data_i[DIST-1:0], data_i[W-1:DIST]};
                    default:      data_o = {{DIST{1'b0}}, data_i[W-1:DIST]};
                endcase
            end
        end
    end

endmodule

// File: rtl/polyshift_pipe.sv
// ---------------------------------------------------------------------------
// polyshift_pipe
// Pipelined bidirectional poly-shifter with valid/ready handshakes.
//   CLK, RST_N          : clock, asynchronous active-low reset
//   IN_VALID / IN_READY : request handshake
//   D_IN, C_IN          : operand and carry-fill word
//   shift_size          : shift amount 0..word_width-1
//   shift_type          : logical / arithmetic / through-carry / rotate
//   shift_dir           : LEFT / RIGHT
//   OUT_VALID/OUT_READY : result handshake
//   D_OUT               : result
// ---------------------------------------------------------------------------
module polyshift_pipe
    import polyshift_pipe_pkg::*;
#(
    parameter int word_width  = 8,
    parameter int PIPE_STAGES = 2
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          IN_VALID,
    output logic                          IN_READY,
    input  logic [word_width-1:0]         D_IN,
    input  logic [word_width-2:0]         C_IN,
    input  logic [$clog2(word_width)-1:0] shift_size,
    input  SHIFT_TYPE                     shift_type,
    input  SHIFT_DIR                      shift_dir,
    output logic                          OUT_VALID,
    input  logic                          OUT_READY,
    output logic [word_width-1:0]         D_OUT
);

    localparam int SW = $clog2(word_width);

    // Everything a request needs while it walks through the ranks.
    typedef struct packed {
        logic [word_width-1:0] data;
        logic [word_width-2:0] carry;
        logic [SW-1:0]         size;
        ps_ctrl_t              ctrl;
    } stage_t;

    stage_t in_pl;
    logic   stall;
    logic   unused_out_bits;

    always_comb begin
        in_pl.data       = D_IN;
        in_pl.carry      = C_IN;
        in_pl.size       = shift_size;
        in_pl.ctrl.valid = IN_VALID;
        in_pl.ctrl.sign  = D_IN[word_width-1];
        in_pl.ctrl.stype = shift_type;
        in_pl.ctrl.dir   = shift_dir;
    end

    for (genvar r = 0; r < PIPE_STAGES; r++) begin : gen_rank
        localparam int FIRST = ps_first_level(r, SW, PIPE_STAGES);
        localparam int CNT   = ps_level_count(r, SW, PIPE_STAGES);

        stage_t src;
        stage_t stage_d;
        stage_t stage_q;

        if (r == 0) begin : g_src_in
            assign src = in_pl;
        end else begin : g_src_prev
            assign src = gen_rank[r-1].stage_q;
        end

        for (genvar j = 0; j < CNT; j++) begin : gen_lvl
            logic [word_width-1:0] data_i;
            logic [word_width-1:0] data_o;
            logic [word_width-2:0] carry_i;
            logic [word_width-2:0] carry_o;

            if (j == 0) begin : g_first
                assign data_i  = src.data;
                assign carry_i = src.carry;
            end else begin : g_next
                assign data_i  = gen_lvl[j-1].data_o;
                assign carry_i = gen_lvl[j-1].carry_o;
            end

            polyshift_level #(
                .W    (word_width),
                .DIST (1 << (FIRST + j))
            ) u_level (
                .data_i  (data_i),
                .carry_i (carry_i),
                .sign_i  (src.ctrl.sign),
                .stype_i (src.ctrl.stype),
                .dir_i   (src.ctrl.dir),
                .en_i    (src.size[FIRST + j]),
                .data_o  (data_o),
                .carry_o (carry_o)
            );
        end

        always_comb begin
            stage_d       = src;
            stage_d.data  = gen_lvl[CNT-1].data_o;
            stage_d.carry = gen_lvl[CNT-1].carry_o;
        end

        // All ranks freeze together on a stall, bubbles included, so the
        // output register can never be overwritten before it is consumed.
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                stage_q <= '0;
            end else if (!stall) begin
                stage_q <= stage_d;
            end
        end
    end

    assign OUT_VALID = gen_rank[PIPE_STAGES-1].stage_q.ctrl.valid;
    assign D_OUT     = gen_rank[PIPE_STAGES-1].stage_q.data;
    assign stall     = OUT_VALID & ~OUT_READY;
    assign IN_READY  = ~stall;

    // The final rank's bookkeeping fields have no consumer.
    assign unused_out_bits = ^{gen_rank[PIPE_STAGES-1].stage_q.carry,
                               gen_rank[PIPE_STAGES-1].stage_q.size,
                               gen_rank[PIPE_STAGES-1].stage_q.ctrl.sign,
                               gen_rank[PIPE_STAGES-1].stage_q.ctrl.stype,
                               gen_rank[PIPE_STAGES-1].stage_q.ctrl.dir};

endmodule
